vga_image_loader: RTL and testbench

//  Source-side writer for the VGA display-buffer write port (write_en/write_addr/write_data).

---
 rtl/vga_image_loader_if.sv | 59 +++++
 rtl/vga_image_loader.sv | 164 ++++++++++++++++
 tb/tb_vga_image_loader.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_image_loader_if.sv
// ----------------------------------------------------------------------------
// vga_image_loader_if
//   Bundles the image loader's ROM read port and VGA display-buffer write port.
//
//   Signals
//     rom_addr    ROM read address (loader -> ROM)
//     rom_data    ROM read data    (ROM -> loader)
//     write_en    buffer write strobe, one word per clock while high
//     write_addr  buffer word address
//     write_data  buffer word data
//     busy        burst in progress
//     img_index   image being loaded or last loaded
//     frame_done  one-clock pulse on the last write of a burst
//
//   Handshake: write_en is the only valid qualifier on the write port. The
//   buffer has no ready. It must accept write_addr/write_data on every clock
//   where write_en is high. The ROM side is a fixed-latency read with no
//   handshake at all.
//
//   Modports
//     master  the loader
//     slave   the ROM + VGA buffer side (or a testbench standing in for them)
// ----------------------------------------------------------------------------
interface vga_image_loader_if #(
    parameter int ROM_AW = 7,
    parameter int BUF_AW = 4,
    parameter int DATA_W = 16
);
    logic [ROM_AW-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              write_en;
    logic [BUF_AW-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic              busy;
    logic [2:0]        img_index;
    logic              frame_done;

    modport master (
        output rom_addr,
        input  rom_data,
        output write_en,
        output write_addr,
        output write_data,
        output busy,
        output img_index,
        output frame_done
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  write_en,
        input  write_addr,
        input  write_data,
        input  busy,
        input  img_index,
        input  frame_done
    );
endinterface

// File: rtl/vga_image_loader.sv
// ----------------------------------------------------------------------------
// vga_image_loader
//   Every INTERVAL clocks, reads one WORDS-word image out of a synchronous ROM
//   and writes it into the VGA display buffer as a gap-free burst. The loader
//   cycles through IMG_COUNT images that are stored back-to-back in the ROM.
//
//   Ports
//     vga_clk      pixel clock. All logic runs on its rising edge.
//     rst_n        synchronous active-low reset
//     bus          vga_image_loader_if.master (ROM read port + buffer write port)
//     dbg_state_o  current FSM state (IDLE=0, ISSUE=1, DRAIN=2)
// ----------------------------------------------------------------------------
module vga_image_loader #(
    parameter int IMG_COUNT = 6,
    parameter int WORDS     = 16,
    parameter int ROM_AW    = 7,
    parameter int BUF_AW    = 4,
    parameter int DATA_W    = 16,
    parameter int INTERVAL  = 6293750,
    parameter int ROM_LAT   = 1
) (
    input  logic                  vga_clk,
    input  logic                  rst_n,
    vga_image_loader_if.master    bus,
    output logic [1:0]            dbg_state_o
);

    localparam int TW  = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam int DCW = $clog2(ROM_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q;
    logic [TW-1:0]     timer_q;
    logic [BUF_AW-1:0] k_q;
    logic [2:0]        img_q;
    logic [ROM_AW-1:0] rom_addr_q;
    logic              busy_q;
    logic [DCW-1:0]    drain_q;

    // Valid tag and word index that travel alongside each ROM read.
    logic [ROM_LAT-1:0] vld_pipe_q;
    logic [BUF_AW-1:0]  k_pipe_q [ROM_LAT];

    logic              start_d;
    logic              issue_d;
    logic [ROM_AW-1:0] base_addr_d;
    logic [2:0]        img_next_d;
    logic [DATA_W-1:0] wdata_d;

    // ------------------------------------------------------------------
    // Interval timer. Reset holds it at 0, and a start fires whenever the
    // timer sits at 0. The first edge out of reset therefore starts image 0
    // at once, and every later start comes exactly INTERVAL clocks after
    // the previous one.
    // ------------------------------------------------------------------
    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else if (timer_q == TW'(INTERVAL - 1)) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + TW'(1);
        end
    end

    always_comb begin
        start_d     = (timer_q == '0);
        issue_d     = (state_q == S_ISSUE);
        base_addr_d = ROM_AW'(img_q) * ROM_AW'(WORDS);
        img_next_d  = (img_q == 3'(IMG_COUNT - 1)) ? 3'd0 : img_q + 3'd1;
    end

    // ------------------------------------------------------------------
    // Burst FSM. A start that arrives while a burst is running is dropped,
    // because only IDLE looks at start_d.
    // ------------------------------------------------------------------
    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            img_q      <= 3'd0;
            rom_addr_q <= '0;
            busy_q     <= 1'b0;
            drain_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_d) begin
                        state_q    <= S_ISSUE;
                        rom_addr_q <= base_addr_d;
                        k_q        <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    // rom_addr_q holds word k_q during this clock. It stops
                    // at the image's last word so it never runs past the ROM.
                    if (k_q == BUF_AW'(WORDS - 1)) begin
                        state_q <= S_DRAIN;
                        drain_q <= '0;
                    end else begin
                        k_q        <= k_q + BUF_AW'(1);
                        rom_addr_q <= rom_addr_q + ROM_AW'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DCW'(ROM_LAT - 1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        img_q   <= img_next_d;
                    end else begin
                        drain_q <= drain_q + DCW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Alignment pipeline. A tag enters on the same edge the ROM samples the
    // address, so both reach the end ROM_LAT clocks later. The index stages
    // load only while tags are being issued, so write_addr keeps its last
    // value between bursts.
    // ------------------------------------------------------------------
    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                vld_pipe_q[i] <= 1'b0;
                k_pipe_q[i]   <= '0;
            end
        end else begin
            vld_pipe_q[0] <= issue_d;
            if (issue_d) begin
                k_pipe_q[0] <= k_q;
            end
            for (int i = 1; i < ROM_LAT; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                k_pipe_q[i]   <= k_pipe_q[i-1];
            end
        end
    end

    assign wdata_d = bus.rom_data;

    assign bus.rom_addr   = rom_addr_q;
    assign bus.write_en   = vld_pipe_q[ROM_LAT-1];
    assign bus.write_addr = k_pipe_q[ROM_LAT-1];
    assign bus.write_data = wdata_d;
    assign bus.busy       = busy_q;
    assign bus.img_index  = img_q;
    assign bus.frame_done = vld_pipe_q[ROM_LAT-1] &&
                            (k_pipe_q[ROM_LAT-1] == BUF_AW'(WORDS - 1));
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_vga_image_loader.sv
module tb_vga_image_loader;

    localparam int INTERVAL = 40;
    localparam int ROM_AW   = 7;
    localparam int BUF_AW   = 4;
    localparam int DATA_W   = 16;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    vga_image_loader_if #(.ROM_AW(ROM_AW), .BUF_AW(BUF_AW), .DATA_W(DATA_W)) bus1 ();
    vga_image_loader_if #(.ROM_AW(ROM_AW), .BUF_AW(BUF_AW), .DATA_W(DATA_W)) bus2 ();
    logic [1:0] dbg1;
    logic [1:0] dbg2;

    vga_image_loader #(.INTERVAL(INTERVAL), .ROM_LAT(1)) u_dut1 (
        .vga_clk     (clk),
        .rst_n       (rst_n),
        .bus         (bus1),
        .dbg_state_o (dbg1)
    );

    vga_image_loader #(.INTERVAL(INTERVAL), .ROM_LAT(2)) u_dut2 (
        .vga_clk     (clk),
        .rst_n       (rst_n),
        .bus         (bus2),
        .dbg_state_o (dbg2)
    );

    // ROM contents: word = {image number, word within image}
    function automatic logic [15:0] rom_word(input logic [6:0] a);
        return {5'd0, a[6:4], 4'd0, a[3:0]};
    endfunction

    logic [15:0] rom2_s1;
    always @(posedge clk) begin
        bus1.rom_data <= rom_word(bus1.rom_addr);
        rom2_s1       <= rom_word(bus2.rom_addr);
        bus2.rom_data <= rom2_s1;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        tests_run++; if (bus1.write_en !== 1'b0) begin tests_failed++; $display("FAIL reset_write_en got %b want 0", bus1.write_en); end
        tests_run++; if (bus1.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", bus1.busy); end
        tests_run++; if (bus1.frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_done got %b want 0", bus1.frame_done); end
        tests_run++; if (bus1.write_addr !== 4'd0) begin tests_failed++; $display("FAIL reset_write_addr got %0d want 0", bus1.write_addr); end
        tests_run++; if (bus1.rom_addr !== 7'd0) begin tests_failed++; $display("FAIL reset_rom_addr got %0d want 0", bus1.rom_addr); end
        tests_run++; if (bus1.img_index !== 3'd0) begin tests_failed++; $display("FAIL reset_img_index got %0d want 0", bus1.img_index); end
        tests_run++; if (dbg1 !== 2'd0) begin tests_failed++; $display("FAIL reset_state got %0d want 0", dbg1); end
        tests_run++; if (bus2.write_en !== 1'b0) begin tests_failed++; $display("FAIL reset_lat2_write_en got %b want 0", bus2.write_en); end
    endtask

    // n = index of the clock edge since the start edge (start edge is 0)
    task automatic test_first_burst();
        logic       we_e, busy_e, fd_e;
        logic [3:0] wa_e;
        logic [6:0] ra_e;
        logic [1:0] st_e;
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            tick();
            we_e   = (n >= 1 && n <= 16);
            busy_e = (n <= 16);
            fd_e   = (n == 16);
            wa_e   = (n == 0) ? 4'd0 : ((n <= 16) ? 4'(n - 1) : 4'd15);
            ra_e   = (n < 15) ? 7'(n) : 7'd15;
            st_e   = (n <= 15) ? 2'd1 : ((n == 16) ? 2'd2 : 2'd0);
            tests_run++; if (bus1.write_en !== we_e) begin tests_failed++; $display("FAIL first_write_en n=%0d got %b want %b", n, bus1.write_en, we_e); end
            tests_run++; if (bus1.write_addr !== wa_e) begin tests_failed++; $display("FAIL first_write_addr n=%0d got %0d want %0d", n, bus1.write_addr, wa_e); end
            if (we_e) begin
                tests_run++; if (bus1.write_data !== {12'h000, wa_e}) begin tests_failed++; $display("FAIL first_write_data n=%0d got %h want %h", n, bus1.write_data, {12'h000, wa_e}); end
            end
            tests_run++; if (bus1.busy !== busy_e) begin tests_failed++; $display("FAIL first_busy n=%0d got %b want %b", n, bus1.busy, busy_e); end
            tests_run++; if (bus1.frame_done !== fd_e) begin tests_failed++; $display("FAIL first_frame_done n=%0d got %b want %b", n, bus1.frame_done, fd_e); end
            tests_run++; if (bus1.rom_addr !== ra_e) begin tests_failed++; $display("FAIL first_rom_addr n=%0d got %0d want %0d", n, bus1.rom_addr, ra_e); end
            tests_run++; if (dbg1 !== st_e) begin tests_failed++; $display("FAIL first_state n=%0d got %0d want %0d", n, dbg1, st_e); end
        end
    endtask

    // continues from edge 20 of the first burst through the 8th burst start
    task automatic test_intervals();
        int         b, off, img, pulses, max_ra;
        int         seen [$];
        int         want [$];
        logic       we_e;
        logic [3:0] wa_e;
        logic [6:0] ra_e;
        logic [2:0] img_e;
        want = '{1, 2, 3, 4, 5, 0, 1};
        pulses = 0;
        max_ra = 0;
        for (int n = 20; n < 7 * INTERVAL + 20; n++) begin
            tick();
            b     = n / INTERVAL;
            off   = n % INTERVAL;
            img   = b % 6;
            we_e  = (off >= 1 && off <= 16);
            wa_e  = we_e ? 4'(off - 1) : 4'd15;
            ra_e  = 7'(img * 16 + ((off < 15) ? off : 15));
            img_e = (off <= 16) ? 3'(img) : 3'((b + 1) % 6);
            tests_run++; if (bus1.write_en !== we_e) begin tests_failed++; $display("FAIL iv_write_en n=%0d got %b want %b", n, bus1.write_en, we_e); end
            tests_run++; if (bus1.write_addr !== wa_e) begin tests_failed++; $display("FAIL iv_write_addr n=%0d got %0d want %0d", n, bus1.write_addr, wa_e); end
            if (we_e) begin
                tests_run++; if (bus1.write_data !== {8'(img), 4'h0, wa_e}) begin tests_failed++; $display("FAIL iv_write_data n=%0d got %h want %h", n, bus1.write_data, {8'(img), 4'h0, wa_e}); end
            end
            tests_run++; if (bus1.busy !== (off <= 16)) begin tests_failed++; $display("FAIL iv_busy n=%0d got %b want %b", n, bus1.busy, (off <= 16)); end
            tests_run++; if (bus1.rom_addr !== ra_e) begin tests_failed++; $display("FAIL iv_rom_addr n=%0d got %0d want %0d", n, bus1.rom_addr, ra_e); end
            tests_run++; if (bus1.img_index !== img_e) begin tests_failed++; $display("FAIL iv_img_index n=%0d got %0d want %0d", n, bus1.img_index, img_e); end
            tests_run++; if (bus1.frame_done !== (off == 16)) begin tests_failed++; $display("FAIL iv_frame_done n=%0d got %b want %b", n, bus1.frame_done, (off == 16)); end
            if (bus1.frame_done === 1'b1) begin
                pulses++;
                seen.push_back(int'(bus1.img_index));
            end
            if (int'(bus1.rom_addr) > max_ra) max_ra = int'(bus1.rom_addr);
        end
        tests_run++; if (pulses != 7) begin tests_failed++; $display("FAIL iv_burst_count got %0d want 7", pulses); end
        tests_run++; if (max_ra != 95) begin tests_failed++; $display("FAIL iv_rom_addr_max got %0d want 95", max_ra); end
        tests_run++; if (seen != want) begin tests_failed++; $display("FAIL iv_image_sequence got %p want %p", seen, want); end
    endtask

    task automatic test_mid_burst_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        // run into the image 1 burst until word 7 is on the write port
        for (int n = 0; n <= INTERVAL + 8; n++) tick();
        tests_run++; if (bus1.write_addr !== 4'd7 || bus1.write_en !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_addr got %0d/%b want 7/1", bus1.write_addr, bus1.write_en); end
        tests_run++; if (bus1.write_data !== 16'h0107) begin tests_failed++; $display("FAIL mid_pre_data got %h want 0107", bus1.write_data); end
        rst_n = 1'b0;
        tick();
        tests_run++; if (bus1.write_en !== 1'b0) begin tests_failed++; $display("FAIL mid_write_en got %b want 0", bus1.write_en); end
        tests_run++; if (bus1.busy !== 1'b0) begin tests_failed++; $display("FAIL mid_busy got %b want 0", bus1.busy); end
        tests_run++; if (bus1.frame_done !== 1'b0) begin tests_failed++; $display("FAIL mid_frame_done got %b want 0", bus1.frame_done); end
        tests_run++; if (bus1.rom_addr !== 7'd0) begin tests_failed++; $display("FAIL mid_rom_addr got %0d want 0", bus1.rom_addr); end
        tests_run++; if (bus1.img_index !== 3'd0) begin tests_failed++; $display("FAIL mid_img_index got %0d want 0", bus1.img_index); end
        tests_run++; if (dbg1 !== 2'd0) begin tests_failed++; $display("FAIL mid_state got %0d want 0", dbg1); end
        rst_n = 1'b1;
        tick();
        tests_run++; if (bus1.busy !== 1'b1) begin tests_failed++; $display("FAIL mid_restart_busy got %b want 1", bus1.busy); end
        tests_run++; if (bus1.rom_addr !== 7'd0) begin tests_failed++; $display("FAIL mid_restart_rom_addr got %0d want 0", bus1.rom_addr); end
        tick();
        tests_run++; if (bus1.write_en !== 1'b1) begin tests_failed++; $display("FAIL mid_restart_write_en got %b want 1", bus1.write_en); end
        tests_run++; if (bus1.write_addr !== 4'd0) begin tests_failed++; $display("FAIL mid_restart_write_addr got %0d want 0", bus1.write_addr); end
        tests_run++; if (bus1.write_data !== 16'h0000) begin tests_failed++; $display("FAIL mid_restart_write_data got %h want 0000", bus1.write_data); end
        tests_run++; if (bus1.img_index !== 3'd0) begin tests_failed++; $display("FAIL mid_restart_img got %0d want 0", bus1.img_index); end
    endtask

    task automatic test_hold_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            tests_run++; if (bus1.write_en !== 1'b0 || bus1.busy !== 1'b0 || bus1.frame_done !== 1'b0) begin tests_failed++; $display("FAIL hold_strobes i=%0d got we=%b busy=%b fd=%b want 0", i, bus1.write_en, bus1.busy, bus1.frame_done); end
            tests_run++; if (bus1.rom_addr !== 7'd0) begin tests_failed++; $display("FAIL hold_rom_addr i=%0d got %0d want 0", i, bus1.rom_addr); end
            tests_run++; if (bus1.write_addr !== 4'd0 || bus1.img_index !== 3'd0) begin tests_failed++; $display("FAIL hold_addr_img i=%0d got %0d/%0d want 0/0", i, bus1.write_addr, bus1.img_index); end
            tests_run++; if (bus2.rom_addr !== 7'd0 || bus2.write_en !== 1'b0) begin tests_failed++; $display("FAIL hold_lat2 i=%0d got ra=%0d we=%b want 0/0", i, bus2.rom_addr, bus2.write_en); end
            if (i >= 1) begin
                tests_run++; if (bus1.write_data !== 16'h0000) begin tests_failed++; $display("FAIL hold_write_data i=%0d got %h want 0000", i, bus1.write_data); end
            end
        end
    endtask

    task automatic test_rom_lat2();
        logic       we_e;
        logic [3:0] wa_e;
        int         writes;
        writes = 0;
        rst_n = 1'b1;
        for (int n = 0; n < 22; n++) begin
            tick();
            we_e = (n >= 2 && n <= 17);
            wa_e = (n < 2) ? 4'd0 : ((n <= 17) ? 4'(n - 2) : 4'd15);
            tests_run++; if (bus2.write_en !== we_e) begin tests_failed++; $display("FAIL lat2_write_en n=%0d got %b want %b", n, bus2.write_en, we_e); end
            tests_run++; if (bus2.write_addr !== wa_e) begin tests_failed++; $display("FAIL lat2_write_addr n=%0d got %0d want %0d", n, bus2.write_addr, wa_e); end
            if (we_e) begin
                tests_run++; if (bus2.write_data !== {12'h000, wa_e}) begin tests_failed++; $display("FAIL lat2_write_data n=%0d got %h want %h", n, bus2.write_data, {12'h000, wa_e}); end
            end
            tests_run++; if (bus2.busy !== (n <= 17)) begin tests_failed++; $display("FAIL lat2_busy n=%0d got %b want %b", n, bus2.busy, (n <= 17)); end
            tests_run++; if (bus2.frame_done !== (n == 17)) begin tests_failed++; $display("FAIL lat2_frame_done n=%0d got %b want %b", n, bus2.frame_done, (n == 17)); end
            if (bus2.write_en === 1'b1) writes++;
        end
        tests_run++; if (writes != 16) begin tests_failed++; $display("FAIL lat2_write_count got %0d want 16", writes); end
        tests_run++; if (bus2.img_index !== 3'd1) begin tests_failed++; $display("FAIL lat2_img_index got %0d want 1", bus2.img_index); end
    endtask

    initial begin
        test_reset();
        test_first_burst();
        test_intervals();
        test_mid_burst_reset();
        test_hold_reset();
        test_rom_lat2();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
